// File: rtl/lc3b_types.sv
// Shared types for the LC-3b MEM-stage stall generator: FSM state, register index,
// and the cap on instructions allowed to overtake a pending load.
package lc3b_types;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC1 = 2'd1,
    ACC2 = 2'd2
  } mem_state_t;

  typedef logic [2:0] reg_idx_t;

  localparam int LEAPFROG_MAX = 2;

endpackage

// File: rtl/mem_stall_gen_if.sv
// MEM/EX/dcache signal bundle for mem_stall_gen; slave is the stall generator,
// master is whoever drives the pipeline side.
interface mem_stall_gen_if;
  import lc3b_types::*;

  logic     mem_valid;
  logic     mem_is_load;
  logic     mem_is_store;
  logic     mem_indirect;
  reg_idx_t mem_dest;
  logic     mem_writes_reg;

  logic     dcache_resp;
  logic     dcache_read;
  logic     dcache_write;
  logic     access_sel;

  logic     ex_valid;
  logic     ex_is_mem;
  logic     ex_is_branch;
  reg_idx_t ex_src1;
  reg_idx_t ex_src2;
  logic     ex_uses_src1;
  logic     ex_uses_src2;
  reg_idx_t ex_dest;
  logic     ex_writes_reg;

  logic     mem_stall;
  logic     leapfrog_load;
  logic     leapfrog_stall;
  logic     mem_done;

  modport slave (
    input  mem_valid, mem_is_load, mem_is_store, mem_indirect, mem_dest, mem_writes_reg,
    input  dcache_resp,
    input  ex_valid, ex_is_mem, ex_is_branch, ex_src1, ex_src2,
    input  ex_uses_src1, ex_uses_src2, ex_dest, ex_writes_reg,
    output dcache_read, dcache_write, access_sel,
    output mem_stall, leapfrog_load, leapfrog_stall, mem_done
  );

  modport master (
    output mem_valid, mem_is_load, mem_is_store, mem_indirect, mem_dest, mem_writes_reg,
    output dcache_resp,
    output ex_valid, ex_is_mem, ex_is_branch, ex_src1, ex_src2,
    output ex_uses_src1, ex_uses_src2, ex_dest, ex_writes_reg,
    input  dcache_read, dcache_write, access_sel,
    input  mem_stall, leapfrog_load, leapfrog_stall, mem_done
  );

endinterface

// File: rtl/mem_hazard_cmp.sv
// RAW/WAW check between the EX instruction and the destination of the load held in MEM.
module mem_hazard_cmp
  import lc3b_types::*;
(
  input  logic     ex_valid,
  input  reg_idx_t ex_src1,
  input  reg_idx_t ex_src2,
  input  logic     ex_uses_src1,
  input  logic     ex_uses_src2,
  input  reg_idx_t ex_dest,
  input  logic     ex_writes_reg,
  input  reg_idx_t mem_dest,
  input  logic     mem_writes_reg,
  output logic     conflict
);

  logic raw1, raw2, waw;

  assign raw1     = ex_uses_src1  && (ex_src1 == mem_dest);
  assign raw2     = ex_uses_src2  && (ex_src2 == mem_dest);
  assign waw      = ex_writes_reg && (ex_dest == mem_dest);
  assign conflict = ex_valid && mem_writes_reg && (raw1 || raw2 || waw);

endmodule

// File: rtl/mem_stall_gen.sv
// MEM-stage dcache sequencer and pipeline stall generator (one or two accesses per op).
// Define MEM_LEAPFROG_EN to let independent ALU ops in EX overtake a pending load.
module mem_stall_gen
  import lc3b_types::*;
(
  input  logic clk,
  input  logic rst,
  mem_stall_gen_if.slave bus
);

  mem_state_t state_q, state_d;
  logic done_c, stall_c, rd_c, wr_c, sel_c;
  logic lf_load_c, lf_stall_c;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    done_c  = 1'b0;
    rd_c    = 1'b0;
    wr_c    = 1'b0;
    sel_c   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.mem_valid) begin
          if (bus.mem_is_load || bus.mem_is_store) state_d = ACC1;
          else                                     done_c  = 1'b1;
        end
      end
      ACC1: begin
        // Indirect ops always read the pointer first, whatever the final direction.
        rd_c = bus.mem_is_load || bus.mem_indirect;
        wr_c = bus.mem_is_store && !bus.mem_indirect;
        if (bus.dcache_resp) begin
          if (bus.mem_indirect) state_d = ACC2;
          else begin
            done_c  = 1'b1;
            state_d = IDLE;
          end
        end
      end
      ACC2: begin
        rd_c  = bus.mem_is_load;
        wr_c  = bus.mem_is_store;
        sel_c = 1'b1;
        if (bus.dcache_resp) begin
          done_c  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign stall_c = (state_q != IDLE) && !done_c;

`ifdef MEM_LEAPFROG_EN
  logic       conflict;
  logic [1:0] lf_cnt_q;
  logic       lf_room;

  mem_hazard_cmp u_hazard (
    .ex_valid       (bus.ex_valid),
    .ex_src1        (bus.ex_src1),
    .ex_src2        (bus.ex_src2),
    .ex_uses_src1   (bus.ex_uses_src1),
    .ex_uses_src2   (bus.ex_uses_src2),
    .ex_dest        (bus.ex_dest),
    .ex_writes_reg  (bus.ex_writes_reg),
    .mem_dest       (bus.mem_dest),
    .mem_writes_reg (bus.mem_writes_reg),
    .conflict       (conflict)
  );

  assign lf_room    = lf_cnt_q < 2'(LEAPFROG_MAX);
  assign lf_load_c  = stall_c && bus.mem_is_load && !bus.mem_is_store && bus.ex_valid &&
                      !bus.ex_is_mem && !bus.ex_is_branch && !conflict && lf_room;
  assign lf_stall_c = stall_c && bus.ex_valid && !lf_load_c;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                      lf_cnt_q <= 2'd0;
    else if (done_c)              lf_cnt_q <= 2'd0;
    else if (lf_load_c && lf_room) lf_cnt_q <= lf_cnt_q + 2'd1;
  end
`else
  logic unused_ex;
  assign unused_ex  = ^{bus.ex_valid, bus.ex_is_mem, bus.ex_is_branch, bus.ex_src1,
                        bus.ex_src2, bus.ex_uses_src1, bus.ex_uses_src2, bus.ex_dest,
                        bus.ex_writes_reg, bus.mem_dest, bus.mem_writes_reg};
  assign lf_load_c  = 1'b0;
  assign lf_stall_c = 1'b0;
`endif

  // Outputs forced low for the whole reset window, even mid-access.
  assign bus.dcache_read    = rd_c       && !rst;
  assign bus.dcache_write   = wr_c       && !rst;
  assign bus.access_sel     = sel_c      && !rst;
  assign bus.mem_done       = done_c     && !rst;
  assign bus.mem_stall      = stall_c    && !rst;
  assign bus.leapfrog_load  = lf_load_c  && !rst;
  assign bus.leapfrog_stall = lf_stall_c && !rst;

endmodule

// File: tb/tb_mem_stall_gen.sv
// Directed scoreboard bench for mem_stall_gen; leapfrog expectations follow MEM_LEAPFROG_EN.
module tb_mem_stall_gen;
  import lc3b_types::*;

`ifdef MEM_LEAPFROG_EN
  localparam bit LF = 1'b1;
`else
  localparam bit LF = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mem_stall_gen_if bus();

  mem_stall_gen dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  typedef struct {
    string      name;
    logic [6:0] exp;
  } sb_t;

  sb_t sb[$];
  sb_t mon_item;
  int  checks = 0;
  int  errors = 0;

  // {dcache_read, dcache_write, access_sel, mem_stall, leapfrog_load, leapfrog_stall, mem_done}
  function automatic logic [6:0] ev(bit rd, bit wr, bit sel, bit st, bit lfl, bit lfs, bit dn);
    return {rd, wr, sel, st, lfl & LF, lfs & LF, dn};
  endfunction

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      logic [6:0] got;
      mon_item = sb.pop_front();
      got = {bus.dcache_read, bus.dcache_write, bus.access_sel, bus.mem_stall,
             bus.leapfrog_load, bus.leapfrog_stall, bus.mem_done};
      checks++;
      if (got !== mon_item.exp) begin
        errors++;
        $display("FAIL %s: got %b expected %b (rd wr sel stall lfl lfs done)",
                 mon_item.name, got, mon_item.exp);
      end
    end
  end

  task automatic tick(input string nm, input logic [6:0] e);
    sb.push_back('{nm, e});
    @(posedge clk);
    #1;
  endtask

  task automatic mem_in(input logic v, input logic ld, input logic st, input logic ind,
                        input logic [2:0] dest, input logic wr);
    bus.mem_valid      = v;
    bus.mem_is_load    = ld;
    bus.mem_is_store   = st;
    bus.mem_indirect   = ind;
    bus.mem_dest       = dest;
    bus.mem_writes_reg = wr;
  endtask

  task automatic ex_in(input logic v, input logic m, input logic br,
                       input logic [2:0] s1, input logic [2:0] s2,
                       input logic u1, input logic u2, input logic [2:0] d, input logic w);
    bus.ex_valid      = v;
    bus.ex_is_mem     = m;
    bus.ex_is_branch  = br;
    bus.ex_src1       = s1;
    bus.ex_src2       = s2;
    bus.ex_uses_src1  = u1;
    bus.ex_uses_src2  = u2;
    bus.ex_dest       = d;
    bus.ex_writes_reg = w;
  endtask

  // ALU op: dest <= a OP b
  task automatic alu(input logic [2:0] d, input logic [2:0] a, input logic [2:0] b);
    ex_in(1'b1, 1'b0, 1'b0, a, b, 1'b1, 1'b1, d, 1'b1);
  endtask

  task automatic ex_none();
    ex_in(1'b0, 1'b0, 1'b0, 3'd0, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  initial begin
    bus.dcache_resp = 1'b0;
    mem_in(1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1);  // non-memory op held during reset
    ex_none();
    @(posedge clk);
    #1;

    // Reset state, then release
    tick("reset_outputs_zero", ev(0,0,0,0,0,0,0));
    rst = 1'b0;
    tick("nonmem_done_idle", ev(0,0,0,0,0,0,1));

    // LDR, response in the fourth access cycle
    mem_in(1'b1, 1'b1, 1'b0, 1'b0, 3'd3, 1'b1);
    tick("ldr_idle", ev(0,0,0,0,0,0,0));
    for (int c = 1; c <= 3; c++) tick("ldr_stall", ev(1,0,0,1,0,0,0));
    bus.dcache_resp = 1'b1;
    tick("ldr_done", ev(1,0,0,0,0,0,1));
    mem_in(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0);
    tick("idle_resp_ignored", ev(0,0,0,0,0,0,0));
    bus.dcache_resp = 1'b0;
    tick("idle_stays_idle", ev(0,0,0,0,0,0,0));

    // LDI, two cycles per access
    mem_in(1'b1, 1'b1, 1'b0, 1'b1, 3'd5, 1'b1);
    tick("ldi_idle", ev(0,0,0,0,0,0,0));
    tick("ldi_acc1_wait", ev(1,0,0,1,0,0,0));
    bus.dcache_resp = 1'b1;
    tick("ldi_acc1_resp", ev(1,0,0,1,0,0,0));
    bus.dcache_resp = 1'b0;
    tick("ldi_acc2_wait", ev(1,0,1,1,0,0,0));
    bus.dcache_resp = 1'b1;
    tick("ldi_acc2_done", ev(1,0,1,0,0,0,1));
    bus.dcache_resp = 1'b0;
    mem_in(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0);
    tick("ldi_after", ev(0,0,0,0,0,0,0));

    // STI: pointer read then data write
    mem_in(1'b1, 1'b0, 1'b1, 1'b1, 3'd0, 1'b0);
    tick("sti_idle", ev(0,0,0,0,0,0,0));
    bus.dcache_resp = 1'b1;
    tick("sti_acc1_read", ev(1,0,0,1,0,0,0));
    tick("sti_acc2_write", ev(0,1,1,0,0,0,1));
    bus.dcache_resp = 1'b0;
    mem_in(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0);
    tick("sti_after", ev(0,0,0,0,0,0,0));

    // LDR R3 miss with independent / dependent EX ops
    mem_in(1'b1, 1'b1, 1'b0, 1'b0, 3'd3, 1'b1);
    alu(3'd1, 3'd2, 3'd4);
    tick("hz_idle", ev(0,0,0,0,0,0,0));
    tick("hz_indep_leapfrog", ev(1,0,0,1,1,0,0));
    alu(3'd1, 3'd3, 3'd4);
    tick("hz_raw_src1", ev(1,0,0,1,0,1,0));
    alu(3'd1, 3'd4, 3'd3);
    tick("hz_raw_src2", ev(1,0,0,1,0,1,0));
    alu(3'd3, 3'd5, 3'd6);
    tick("hz_waw", ev(1,0,0,1,0,1,0));
    ex_none();
    bus.dcache_resp = 1'b1;
    tick("hz_done", ev(1,0,0,0,0,0,1));
    bus.dcache_resp = 1'b0;

    // Load miss 6 cycles, three independent ALU ops: only two may leapfrog
    mem_in(1'b1, 1'b1, 1'b0, 1'b0, 3'd2, 1'b1);
    tick("cnt_idle", ev(0,0,0,0,0,0,0));
    alu(3'd1, 3'd3, 3'd4);
    tick("cnt_first", ev(1,0,0,1,1,0,0));
    alu(3'd5, 3'd6, 3'd7);
    tick("cnt_second", ev(1,0,0,1,1,0,0));
    alu(3'd4, 3'd1, 3'd0);
    tick("cnt_third_stall", ev(1,0,0,1,0,1,0));
    tick("cnt_third_hold", ev(1,0,0,1,0,1,0));
    ex_none();
    tick("cnt_ex_empty", ev(1,0,0,1,0,0,0));
    bus.dcache_resp = 1'b1;
    tick("cnt_done", ev(1,0,0,0,0,0,1));
    bus.dcache_resp = 1'b0;

    // Counter cleared; branch and memory ops in EX never leapfrog
    mem_in(1'b1, 1'b1, 1'b0, 1'b0, 3'd2, 1'b0);
    tick("clr_idle", ev(0,0,0,0,0,0,0));
    ex_in(1'b1, 1'b0, 1'b1, 3'd0, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0);
    tick("branch_stall", ev(1,0,0,1,0,1,0));
    ex_in(1'b1, 1'b1, 1'b0, 3'd5, 3'd0, 1'b1, 1'b0, 3'd6, 1'b1);
    tick("exmem_stall", ev(1,0,0,1,0,1,0));
    alu(3'd1, 3'd2, 3'd4);  // reads R2 but the load writes no register
    tick("clr_nowrite_leapfrog", ev(1,0,0,1,1,0,0));
    ex_none();
    bus.dcache_resp = 1'b1;
    tick("clr_done", ev(1,0,0,0,0,0,1));
    bus.dcache_resp = 1'b0;

    // STR miss: never leapfrogs; reset abandons the access
    mem_in(1'b1, 1'b0, 1'b1, 1'b0, 3'd3, 1'b0);
    alu(3'd1, 3'd2, 3'd4);
    tick("str_idle", ev(0,0,0,0,0,0,0));
    tick("str_no_leapfrog", ev(0,1,0,1,0,1,0));
    rst = 1'b1;
    tick("rst_mid_acc1", ev(0,0,0,0,0,0,0));
    tick("rst_held", ev(0,0,0,0,0,0,0));
    rst = 1'b0;
    tick("rst_release_idle", ev(0,0,0,0,0,0,0));
    tick("str_restart", ev(0,1,0,1,0,1,0));
    ex_none();
    bus.dcache_resp = 1'b1;
    tick("str_done", ev(0,1,0,0,0,0,1));
    bus.dcache_resp = 1'b0;
    mem_in(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0);
    tick("final_idle", ev(0,0,0,0,0,0,0));

    @(posedge clk);
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
